// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32x32 register file and its write-back logic.
package regfile_pkg;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 2 ** AW;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] reg_data_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. On a tie the requester not granted last wins;
// out of reset req[0] is favoured.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // prio1 = 1 means req[1] wins the next tie
    logic prio1;

    assign gnt[0] = req[0] & (~req[1] | ~prio1);
    assign gnt[1] = req[1] & (~req[0] |  prio1);

    // Priority pointer moves only when a grant is actually given
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio1 <= 1'b0;
        end else if (gnt[0]) begin
            prio1 <= 1'b1;
        end else if (gnt[1]) begin
            prio1 <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Write-back arbiter and pending-write scoreboard in front of the register file
// write port. Issue stalls on RAW/WAW hazards; ALU and load results share the
// single write port through a round-robin arbiter.
module regfile_wb_scoreboard
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_dst,
    input  logic [AW-1:0]   iss_src_a,
    input  logic [AW-1:0]   iss_src_b,
    output logic            iss_ready,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_dst,
    input  logic [DW-1:0]   alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [AW-1:0]   mem_dst,
    input  logic [DW-1:0]   mem_data,
    output logic            mem_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_wa,
    output logic [DW-1:0]   rf_wd,
    output logic [NREG-1:0] busy,
    output logic            wb_err
);

    logic [1:0]      gnt;
    logic            wb_fire;
    reg_addr_t       wb_dst;
    reg_data_t       wb_data;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({mem_valid, alu_valid}),
        .gnt   (gnt)
    );

    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];
    assign wb_fire   = |gnt;
    assign wb_dst    = gnt[1] ? mem_dst  : alu_dst;
    assign wb_data   = gnt[1] ? mem_data : alu_data;

    // Registered busy only: a clear in flight is deliberately not bypassed here
    assign iss_ready = ~busy[iss_src_a] & ~busy[iss_src_b] & ~busy[iss_dst];

    // One-hot set from an accepted issue and clear from a granted write-back
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_valid && iss_ready) begin
            set_vec[iss_dst] = 1'b1;
        end
        if (wb_fire) begin
            clr_vec[wb_dst] = 1'b1;
        end
    end

    // Scoreboard update; set and clear of different registers both apply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_vec) | set_vec;
        end
    end

    // Write-port registers; address and data hold when nothing is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= wb_fire;
            if (wb_fire) begin
                rf_wa <= wb_dst;
                rf_wd <= wb_data;
            end
        end
    end

    // Sticky flag for a write-back to a register with no result outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_err <= 1'b0;
        end else if (wb_fire && !busy[wb_dst]) begin
            wb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Bench for regfile_wb_scoreboard: directed corner sequences, a vector table for
// arbitration, and a randomized run against a behavioural scoreboard model.
module tb_regfile_wb_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid;
    logic [4:0]  iss_dst, iss_src_a, iss_src_b;
    logic        iss_ready;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_dst, mem_dst;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] busy;
    logic        wb_err;

    int total = 0;
    int bad   = 0;

    regfile_wb_scoreboard dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_dst   (iss_dst),
        .iss_src_a (iss_src_a),
        .iss_src_b (iss_src_b),
        .iss_ready (iss_ready),
        .alu_valid (alu_valid),
        .alu_dst   (alu_dst),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_dst   (mem_dst),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .busy      (busy),
        .wb_err    (wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 0; iss_dst = 0; iss_src_a = 0; iss_src_b = 0;
        alu_valid = 0; alu_dst = 0; alu_data = 0;
        mem_valid = 0; mem_dst = 0; mem_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        #1;
    endtask

    task automatic issue_one(input logic [4:0] d);
        iss_valid = 1; iss_dst = d; iss_src_a = 0; iss_src_b = 0;
        #1;
        chk("issue_ready", iss_ready, 1);
        step();
        iss_valid = 0;
    endtask

    typedef struct {
        logic        av;
        logic [4:0]  ad;
        logic [31:0] adat;
        logic        mv;
        logic [4:0]  md;
        logic [31:0] mdat;
        logic        e_ar;
        logic        e_mr;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[8];

    // Behavioural model state for the randomized phase
    logic [31:0] m_busy;
    bit          m_mem_last;
    bit          m_we, m_err;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    function automatic logic [4:0] pick_dst(input logic [31:0] pend);
        logic [4:0] d;
        d = 5'($urandom_range(31));
        if (pend != 0 && $urandom_range(3) != 0) begin
            for (int k = 0; k < 32; k++) begin
                if (pend[(int'(d) + k) % 32]) return 5'((int'(d) + k) % 32);
            end
        end
        return d;
    endfunction

    initial begin
        idle_inputs();
        rst_n = 0;
        #2;
        chk("rst_we", rf_we, 0);
        chk("rst_wa", rf_wa, 0);
        chk("rst_wd", rf_wd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", wb_err, 0);
        step();
        rst_n = 1;
        step();

        // ---- asynchronous reset mid-operation with busy=0x30 and a write in flight
        issue_one(5'd4);
        issue_one(5'd5);
        alu_valid = 1; alu_dst = 9; alu_data = 32'h5555_AAAA;
        step();
        alu_valid = 0;
        chk("pre_rst_busy", busy, 32'h30);
        chk("pre_rst_we", rf_we, 1);
        chk("pre_rst_err", wb_err, 1);
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_we", rf_we, 0);
        chk("async_rst_wa", rf_wa, 0);
        chk("async_rst_err", wb_err, 0);
        step();
        rst_n = 1;
        #1;

        // ---- RAW stall
        iss_valid = 1; iss_dst = 5; iss_src_a = 1; iss_src_b = 2;
        #1;
        chk("raw_first_ready", iss_ready, 1);
        step();
        chk("raw_busy5", busy, 32'h20);
        iss_dst = 10; iss_src_a = 5; iss_src_b = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("raw_stall", iss_ready, 0);
            step();
        end
        chk("raw_busy_held", busy, 32'h20);
        alu_valid = 1; alu_dst = 5; alu_data = 32'hDEADBEEF;
        #1;
        chk("raw_alu_ready", alu_ready, 1);
        chk("raw_no_bypass", iss_ready, 0);
        step();
        alu_valid = 0;
        chk("raw_we", rf_we, 1);
        chk("raw_wa", rf_wa, 5);
        chk("raw_wd", rf_wd, 32'hDEADBEEF);
        chk("raw_busy_clr", busy, 0);
        chk("raw_ready_after", iss_ready, 1);
        step();
        iss_valid = 0;
        chk("raw_dep_issued", busy, 32'h400);
        chk("raw_we_drop", rf_we, 0);
        chk("raw_wa_hold", rf_wa, 5);

        // ---- WAW stall
        issue_one(5'd6);
        iss_valid = 1; iss_dst = 6; iss_src_a = 0; iss_src_b = 0;
        #1;
        chk("waw_stall", iss_ready, 0);
        step();
        chk("waw_stall2", iss_ready, 0);
        mem_valid = 1; mem_dst = 6; mem_data = 32'h0000_0666;
        #1;
        chk("waw_mem_ready", mem_ready, 1);
        step();
        mem_valid = 0; iss_valid = 0;
        chk("waw_ready_after", iss_ready, 1);
        chk("waw_wa", rf_wa, 6);
        chk("waw_err_clean", wb_err, 0);

        // ---- spurious write-back
        do_reset();
        mem_valid = 1; mem_dst = 7; mem_data = 32'h1234;
        step();
        mem_valid = 0;
        chk("spur_we", rf_we, 1);
        chk("spur_wa", rf_wa, 7);
        chk("spur_wd", rf_wd, 32'h1234);
        chk("spur_err", wb_err, 1);
        step();
        step();
        chk("spur_err_sticky", wb_err, 1);
        chk("spur_we_low", rf_we, 0);

        // ---- back-to-back 32 issues then 32 write-backs
        do_reset();
        for (int i = 0; i < 32; i++) begin
            iss_valid = 1; iss_dst = 5'(i); iss_src_a = 5'(i); iss_src_b = 5'(i);
            #1;
            chk("b2b_iss_ready", iss_ready, 1);
            step();
        end
        iss_valid = 0;
        chk("b2b_busy_full", busy, 32'hFFFF_FFFF);
        for (int i = 0; i < 32; i++) begin
            alu_valid = 1; alu_dst = 5'(i); alu_data = 32'hC0DE_0000 + 32'(i);
            #1;
            chk("b2b_alu_ready", alu_ready, 1);
            step();
            chk("b2b_we", rf_we, 1);
            chk("b2b_wa", rf_wa, 64'(i));
            chk("b2b_wd", rf_wd, 64'(32'hC0DE_0000 + 32'(i)));
            chk("b2b_busy", busy, (64'hFFFF_FFFF << (i + 1)) & 64'hFFFF_FFFF);
        end
        alu_valid = 0;
        step();
        chk("b2b_we_end", rf_we, 0);
        chk("b2b_err", wb_err, 0);

        // ---- arbitration vector table, starting from reset
        vecs[0] = '{1, 3,  32'hA000_0003, 1, 4,  32'hB000_0004, 1, 0, 1, 3,  32'hA000_0003};
        vecs[1] = '{1, 8,  32'hA000_0008, 1, 4,  32'hB000_0004, 0, 1, 1, 4,  32'hB000_0004};
        vecs[2] = '{1, 8,  32'hA000_0008, 1, 9,  32'hB000_0009, 1, 0, 1, 8,  32'hA000_0008};
        vecs[3] = '{1, 10, 32'hA000_000A, 1, 9,  32'hB000_0009, 0, 1, 1, 9,  32'hB000_0009};
        vecs[4] = '{1, 10, 32'hA000_000A, 0, 0,  32'h0,         1, 0, 1, 10, 32'hA000_000A};
        vecs[5] = '{0, 0,  32'h0,         0, 0,  32'h0,         0, 0, 0, 10, 32'hA000_000A};
        vecs[6] = '{0, 0,  32'h0,         1, 11, 32'hB000_000B, 0, 1, 1, 11, 32'hB000_000B};
        vecs[7] = '{1, 12, 32'hA000_000C, 1, 13, 32'hB000_000D, 1, 0, 1, 12, 32'hA000_000C};
        do_reset();
        issue_one(5'd3);
        issue_one(5'd4);
        chk("tie_busy_pre", busy, 32'h18);
        for (int i = 0; i < 8; i++) begin
            alu_valid = vecs[i].av; alu_dst = vecs[i].ad; alu_data = vecs[i].adat;
            mem_valid = vecs[i].mv; mem_dst = vecs[i].md; mem_data = vecs[i].mdat;
            #1;
            chk($sformatf("vec%0d_alu_ready", i), alu_ready, vecs[i].e_ar);
            chk($sformatf("vec%0d_mem_ready", i), mem_ready, vecs[i].e_mr);
            step();
            chk($sformatf("vec%0d_we", i), rf_we, vecs[i].e_we);
            chk($sformatf("vec%0d_wa", i), rf_wa, vecs[i].e_wa);
            chk($sformatf("vec%0d_wd", i), rf_wd, vecs[i].e_wd);
            if (i == 1) chk("tie_busy_drained", busy, 0);
        end
        idle_inputs();
        chk("tie_err", wb_err, 1);

        // ---- randomized run against the model
        do_reset();
        m_busy = 0; m_mem_last = 1; m_we = 0; m_err = 0; m_wa = 0; m_wd = 0;
        begin
            bit          a_pend, b_pend;
            logic [4:0]  a_dst, b_dst;
            logic [31:0] a_dat, b_dat;
            bit          e_iss, e_ar, e_mr;
            a_pend = 0; b_pend = 0; a_dst = 0; b_dst = 0; a_dat = 0; b_dat = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                if (!a_pend && $urandom_range(2) == 0) begin
                    a_pend = 1; a_dst = pick_dst(m_busy); a_dat = $urandom;
                end
                if (!b_pend && $urandom_range(2) == 0) begin
                    b_pend = 1; b_dst = pick_dst(m_busy); b_dat = $urandom;
                end
                alu_valid = a_pend; alu_dst = a_dst; alu_data = a_dat;
                mem_valid = b_pend; mem_dst = b_dst; mem_data = b_dat;
                iss_valid = 1'($urandom_range(1));
                iss_dst   = 5'($urandom_range(7));
                iss_src_a = 5'($urandom_range(7));
                iss_src_b = 5'($urandom_range(7));
                if ((a_pend && iss_dst == a_dst) || (b_pend && iss_dst == b_dst)) iss_valid = 0;
                #1;
                e_iss = !m_busy[iss_src_a] && !m_busy[iss_src_b] && !m_busy[iss_dst];
                e_ar  = a_pend && (!b_pend || m_mem_last);
                e_mr  = b_pend && (!a_pend || !m_mem_last);
                chk("rnd_iss_ready", iss_ready, e_iss);
                chk("rnd_alu_ready", alu_ready, e_ar);
                chk("rnd_mem_ready", mem_ready, e_mr);
                chk("rnd_busy", busy, m_busy);
                chk("rnd_we", rf_we, m_we);
                chk("rnd_wa", rf_wa, m_wa);
                chk("rnd_wd", rf_wd, m_wd);
                chk("rnd_err", wb_err, m_err);
                m_we = e_ar || e_mr;
                if (e_ar) begin
                    if (!m_busy[a_dst]) m_err = 1;
                    m_busy[a_dst] = 0; m_wa = a_dst; m_wd = a_dat;
                    m_mem_last = 0; a_pend = 0;
                end else if (e_mr) begin
                    if (!m_busy[b_dst]) m_err = 1;
                    m_busy[b_dst] = 0; m_wa = b_dst; m_wd = b_dat;
                    m_mem_last = 1; b_pend = 0;
                end
                if (iss_valid && e_iss) m_busy[iss_dst] = 1;
                step();
            end
        end
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
